// File: rtl/cpu_types_pkg.sv
// Shared types for the L1 data cache: address decode, frame layout, controller states.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DTAG_W   = 26;
    localparam int unsigned DIDX_W   = 3;
    localparam int unsigned DBLK_W   = 1;
    localparam int unsigned DBYT_W   = 2;
    localparam int unsigned DWAY_ASS = 2;
    localparam int unsigned DSETS    = 8;
    localparam int unsigned DWORDS   = 2;
    localparam int unsigned FCNT_W   = DIDX_W + 1;

    localparam logic [WORD_W-1:0] HITCNT_ADDR_DEF = 32'h0000_3100;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic [DBLK_W-1:0] blkoff;
        logic [DBYT_W-1:0] bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [DTAG_W-1:0]        tag;
        word_t [DWORDS-1:0]       data;
    } dframe_t;

    typedef enum logic [3:0] {
        DC_IDLE   = 4'd0,
        DC_WB0    = 4'd1,
        DC_WB1    = 4'd2,
        DC_FETCH0 = 4'd3,
        DC_FETCH1 = 4'd4,
        DC_FLUSH  = 4'd5,
        DC_FL_W0  = 4'd6,
        DC_FL_W1  = 4'd7,
        DC_HITCNT = 4'd8,
        DC_DONE   = 4'd9
    } dcache_state_t;

    // Word address of one block word, byte offset forced to zero.
    function automatic word_t blk_addr(input logic [DTAG_W-1:0] tag,
                                       input logic [DIDX_W-1:0] idx,
                                       input logic [DBLK_W-1:0] blk);
        return {tag, idx, blk, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// 8-set x 2-way frame storage with per-set LRU bit; combinational lookup, registered writes.
module dcache_frame_array
    import cpu_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DIDX_W-1:0] lk_idx,
    input  logic [DTAG_W-1:0] lk_tag,
    output logic              hit,
    output logic              hit_way,
    output dframe_t           hit_frame,
    output logic              victim_way,
    input  logic [DIDX_W-1:0] rd_idx,
    input  logic              rd_way,
    output dframe_t           rd_frame,
    input  logic              wr_en,
    input  logic [DIDX_W-1:0] wr_idx,
    input  logic              wr_way,
    input  dframe_t           wr_frame,
    input  logic              lru_we,
    input  logic [DIDX_W-1:0] lru_idx,
    input  logic              lru_val
);

    dframe_t          frames [DSETS][DWAY_ASS];
    logic [DSETS-1:0] lru;

    dframe_t f0;
    dframe_t f1;
    logic    m0;
    logic    m1;

    // Tag compare on the requested set; invalid ways are filled before evicting by LRU.
    always_comb begin
        f0         = frames[lk_idx][0];
        f1         = frames[lk_idx][1];
        m0         = f0.valid && (f0.tag == lk_tag);
        m1         = f1.valid && (f1.tag == lk_tag);
        hit        = m0 || m1;
        hit_way    = !m0;
        hit_frame  = m0 ? f0 : f1;
        victim_way = !f0.valid ? 1'b0 : (!f1.valid ? 1'b1 : lru[lk_idx]);
        rd_frame   = frames[rd_idx][rd_way];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames <= '{default: '0};
            lru    <= '0;
        end else begin
            if (wr_en) begin
                frames[wr_idx][wr_way] <= wr_frame;
            end
            if (lru_we) begin
                lru[lru_idx] <= lru_val;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate 2-way L1 data cache controller with halt-time flush and hit counter.
module dcache_ctrl
    import cpu_types_pkg::*;
#(
    parameter logic [WORD_W-1:0] HITCNT_ADDR = HITCNT_ADDR_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              flushed,
    input  logic              dwait,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic [WORD_W-1:0] dload
);

    localparam logic [3:0] S_IDLE   = 4'(DC_IDLE);
    localparam logic [3:0] S_WB0    = 4'(DC_WB0);
    localparam logic [3:0] S_WB1    = 4'(DC_WB1);
    localparam logic [3:0] S_FETCH0 = 4'(DC_FETCH0);
    localparam logic [3:0] S_FETCH1 = 4'(DC_FETCH1);
    localparam logic [3:0] S_FLUSH  = 4'(DC_FLUSH);
    localparam logic [3:0] S_FL_W0  = 4'(DC_FL_W0);
    localparam logic [3:0] S_FL_W1  = 4'(DC_FL_W1);
    localparam logic [3:0] S_HITCNT = 4'(DC_HITCNT);
    localparam logic [3:0] S_DONE   = 4'(DC_DONE);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(DSETS * DWAY_ASS - 1);

    logic [3:0]        state,  state_n;
    logic              vway,   vway_n;
    logic [FCNT_W-1:0] fcnt,   fcnt_n;
    logic [WORD_W-1:0] hitcnt, hitcnt_n;

    dcachef_t req;
    logic     req_any;
    logic     unused_bytoff;

    logic              hit;
    logic              hit_way;
    dframe_t           hit_frame;
    logic              victim_way;
    logic [DIDX_W-1:0] rd_idx;
    logic              rd_way;
    dframe_t           rd_frame;
    logic              wr_en;
    logic [DIDX_W-1:0] wr_idx;
    logic              wr_way;
    dframe_t           wr_frame;
    logic              lru_we;
    logic [DIDX_W-1:0] lru_idx;
    logic              lru_val;

    assign req           = dcachef_t'(dmemaddr);
    assign req_any       = dmemREN || dmemWEN;
    assign unused_bytoff = ^req.bytoff;

    dcache_frame_array u_frames (
        .clk        (CLK),
        .rst        (RST),
        .lk_idx     (req.idx),
        .lk_tag     (req.tag),
        .hit        (hit),
        .hit_way    (hit_way),
        .hit_frame  (hit_frame),
        .victim_way (victim_way),
        .rd_idx     (rd_idx),
        .rd_way     (rd_way),
        .rd_frame   (rd_frame),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_way     (wr_way),
        .wr_frame   (wr_frame),
        .lru_we     (lru_we),
        .lru_idx    (lru_idx),
        .lru_val    (lru_val)
    );

    // Read port: candidate victim while idle, latched victim during a miss, flush frame while flushing.
    always_comb begin
        rd_idx = req.idx;
        rd_way = vway;
        if (state == S_IDLE) begin
            rd_way = victim_way;
        end else if (state inside {S_FLUSH, S_FL_W0, S_FL_W1}) begin
            rd_idx = fcnt[FCNT_W-1:1];
            rd_way = fcnt[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            vway   <= 1'b0;
            fcnt   <= '0;
            hitcnt <= '0;
        end else begin
            state  <= state_n;
            vway   <= vway_n;
            fcnt   <= fcnt_n;
            hitcnt <= hitcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        vway_n   = vway;
        fcnt_n   = fcnt;
        hitcnt_n = hitcnt;
        wr_en    = 1'b0;
        wr_idx   = req.idx;
        wr_way   = vway;
        wr_frame = rd_frame;
        lru_we   = 1'b0;
        lru_idx  = req.idx;
        lru_val  = ~vway;
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        flushed  = 1'b0;

        case (state)
            S_IDLE: begin
                if (halt) begin
                    state_n = S_FLUSH;
                    fcnt_n  = '0;
                end else if (req_any) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = hit_frame.data[req.blkoff];
                        hitcnt_n = hitcnt + 32'd1;
                        lru_we   = 1'b1;
                        lru_val  = ~hit_way;
                        if (dmemWEN) begin
                            wr_en                      = 1'b1;
                            wr_way                     = hit_way;
                            wr_frame                   = hit_frame;
                            wr_frame.data[req.blkoff]  = dmemstore;
                            wr_frame.dirty             = 1'b1;
                        end
                    end else begin
                        hitcnt_n = hitcnt - 32'd1;
                        vway_n   = victim_way;
                        state_n  = (rd_frame.valid && rd_frame.dirty) ? S_WB0 : S_FETCH0;
                    end
                end
            end
            S_WB0: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(rd_frame.tag, req.idx, 1'b0);
                dstore = rd_frame.data[0];
                if (!dwait) state_n = S_WB1;
            end
            S_WB1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(rd_frame.tag, req.idx, 1'b1);
                dstore = rd_frame.data[1];
                if (!dwait) begin
                    wr_en          = 1'b1;
                    wr_frame.dirty = 1'b0;
                    state_n        = S_FETCH0;
                end
            end
            S_FETCH0: begin
                dREN  = 1'b1;
                daddr = blk_addr(req.tag, req.idx, 1'b0);
                if (!dwait) begin
                    wr_en            = 1'b1;
                    wr_frame.data[0] = dload;
                    state_n          = S_FETCH1;
                end
            end
            S_FETCH1: begin
                dREN  = 1'b1;
                daddr = blk_addr(req.tag, req.idx, 1'b1);
                if (!dwait) begin
                    wr_en            = 1'b1;
                    wr_frame.valid   = 1'b1;
                    wr_frame.dirty   = 1'b0;
                    wr_frame.tag     = req.tag;
                    wr_frame.data[1] = dload;
                    lru_we           = 1'b1;
                    state_n          = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (rd_frame.valid && rd_frame.dirty) begin
                    state_n = S_FL_W0;
                end else if (fcnt == FCNT_LAST) begin
                    state_n = S_HITCNT;
                end else begin
                    fcnt_n = fcnt + FCNT_W'(1);
                end
            end
            S_FL_W0: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(rd_frame.tag, fcnt[FCNT_W-1:1], 1'b0);
                dstore = rd_frame.data[0];
                if (!dwait) state_n = S_FL_W1;
            end
            S_FL_W1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(rd_frame.tag, fcnt[FCNT_W-1:1], 1'b1);
                dstore = rd_frame.data[1];
                if (!dwait) begin
                    wr_en          = 1'b1;
                    wr_idx         = fcnt[FCNT_W-1:1];
                    wr_way         = fcnt[0];
                    wr_frame.dirty = 1'b0;
                    if (fcnt == FCNT_LAST) begin
                        state_n = S_HITCNT;
                    end else begin
                        fcnt_n  = fcnt + FCNT_W'(1);
                        state_n = S_FLUSH;
                    end
                end
            end
            S_HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hitcnt;
                if (!dwait) state_n = S_DONE;
            end
            S_DONE: begin
                flushed = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: reference cache/memory model feeds expected memory and load queues.
module tb_dcache_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, halt, dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait;
    logic [31:0] dload;

    always #5 CLK = ~CLK;

    dcache_ctrl dut (
        .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dwait(dwait), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dload(dload)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { bit st; logic [31:0] data; } rsp_t;

    txn_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: per-set ways, LRU = way to evict next, plus a flat memory image.
    bit          m_valid [8][2];
    bit          m_dirty [8][2];
    logic [25:0] m_tag   [8][2];
    logic [31:0] m_data  [8][2][2];
    bit          m_lru   [8];
    logic [31:0] exp_hits;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] rsp_mem [logic [31:0]];

    bit hold_busy = 1'b0;
    int allowed   = 0;
    int busy_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h0000_1357;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rsp_rd(input logic [31:0] a);
        return rsp_mem.exists(a) ? rsp_mem[a] : init_val(a);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        exp_hits = 32'd0;
    endfunction

    function automatic void model_access(input bit st, input logic [31:0] addr, input logic [31:0] data);
        logic [2:0]  idx;
        logic [25:0] tag;
        logic [31:0] a;
        int          b;
        int          w;
        idx = addr[5:3];
        tag = addr[31:6];
        b   = int'(addr[2]);
        w   = -1;
        for (int k = 0; k < 2; k++)
            if (m_valid[idx][k] && m_tag[idx][k] == tag) w = k;
        if (w < 0) begin
            exp_hits = exp_hits - 32'd1;
            w = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
            if (m_dirty[idx][w]) begin
                for (int k = 0; k < 2; k++) begin
                    a = {m_tag[idx][w], idx, 1'(k), 2'b00};
                    ref_mem[a] = m_data[idx][w][k];
                    exp_q.push_back('{1'b1, a, m_data[idx][w][k]});
                end
            end
            for (int k = 0; k < 2; k++) begin
                a = {tag, idx, 1'(k), 2'b00};
                m_data[idx][w][k] = ref_rd(a);
                exp_q.push_back('{1'b0, a, 32'd0});
            end
            m_valid[idx][w] = 1'b1;
            m_dirty[idx][w] = 1'b0;
            m_tag[idx][w]   = tag;
        end
        exp_hits   = exp_hits + 32'd1;
        m_lru[idx] = (w == 0);
        if (st) begin
            m_data[idx][w][b] = data;
            m_dirty[idx][w]   = 1'b1;
            rsp_q.push_back('{1'b1, data});
        end else begin
            rsp_q.push_back('{1'b0, m_data[idx][w][b]});
        end
    endfunction

    function automatic void model_flush();
        logic [31:0] a;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    for (int k = 0; k < 2; k++) begin
                        a = {m_tag[s][w], 3'(s), 1'(k), 2'b00};
                        exp_q.push_back('{1'b1, a, m_data[s][w][k]});
                    end
                    m_dirty[s][w] = 1'b0;
                end
        exp_q.push_back('{1'b1, HITCNT_ADDR_DEF, exp_hits});
    endfunction

    // Memory responder: random busy cycles, optional hold, serves reads from its own image.
    initial begin
        dwait = 1'b1;
        dload = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if ((dREN || dWEN) && !RST) begin
                if (hold_busy && allowed == 0) begin
                    dwait = 1'b1;
                end else if (busy_left > 0) begin
                    dwait = 1'b1;
                    busy_left--;
                end else begin
                    dwait     = 1'b0;
                    dload     = rsp_rd(daddr);
                    busy_left = int'($urandom_range(0, 2));
                    if (hold_busy) allowed--;
                end
            end else begin
                dwait = 1'b1;
            end
        end
    end

    // Monitor: pops expected memory transfers and load results as the DUT presents them.
    initial begin
        txn_t t;
        rsp_t r;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (dREN || dWEN) begin
                    check("req_exclusive", 32'(dREN && dWEN), 32'd0);
                    if (!dwait) begin
                        if (dWEN) rsp_mem[daddr] = dstore;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_txn: got wen=%0b addr %h expected none", dWEN, daddr);
                        end else begin
                            t = exp_q.pop_front();
                            check("txn_kind", 32'(dWEN), 32'(t.wr));
                            check("txn_addr", daddr, t.addr);
                            if (t.wr) check("txn_data", dstore, t.data);
                        end
                    end
                end
                if (dhit) begin
                    check("dhit_in_halt", 32'(halt), 32'd0);
                    if (rsp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_dhit: got dhit=1 expected 0 addr %h", dmemaddr);
                    end else begin
                        r = rsp_q.pop_front();
                        if (!r.st) check("load_data", dmemload, r.data);
                    end
                end
            end
        end
    end

    task automatic issue(input bit st, input bit both, input logic [31:0] a, input logic [31:0] d);
        model_access(st, a, d);
        dmemREN   = !st || both;
        dmemWEN   = st;
        dmemaddr  = a;
        dmemstore = d;
    endtask

    task automatic finish_req();
        bit got = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            if (dhit) begin
                got = 1'b1;
                break;
            end
        end
        check("hit_within_bound", 32'(got), 32'd1);
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    initial begin
        bit          got;
        bit          st, both;
        logic [31:0] a;
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = 32'd0; dmemstore = 32'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_dhit", 32'(dhit), 32'd0);
        check("rst_dmemload", dmemload, 32'd0);
        check("rst_flushed", 32'(flushed), 32'd0);
        check("rst_dren", 32'(dREN), 32'd0);
        check("rst_dwen", 32'(dWEN), 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dstore", dstore, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Reset while the second fill word is stalled abandons the miss.
        allowed = 1; hold_busy = 1'b1;
        issue(1'b0, 1'b0, 32'h40, 32'd0);
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (dREN && daddr == 32'h44) begin
                got = 1'b1;
                break;
            end
        end
        check("reach_fetch1", 32'(got), 32'd1);
        repeat (3) @(negedge CLK);
        check("fetch1_stall_ren", 32'(dREN), 32'd1);
        check("fetch1_stall_addr", daddr, 32'h44);
        @(posedge CLK);
        #1 RST = 1'b1;
        exp_q.delete();
        rsp_q.delete();
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        check("rst_abort_dren", 32'(dREN), 32'd0);
        check("rst_abort_dhit", 32'(dhit), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        hold_busy = 1'b0;
        issue(1'b0, 1'b0, 32'h40, 32'd0);
        finish_req();

        // Second word hits with no memory traffic; REN+WEN together acts as a store.
        issue(1'b0, 1'b0, 32'h44, 32'd0);          finish_req();
        issue(1'b1, 1'b1, 32'h40, 32'h0000_1234);  finish_req();
        issue(1'b0, 1'b0, 32'h40, 32'd0);          finish_req();
        issue(1'b1, 1'b0, 32'h80, 32'h0000_1234);  finish_req();
        issue(1'b0, 1'b0, 32'h80, 32'd0);          finish_req();

        // Conflict traffic in set 0 forces LRU eviction with write-back.
        issue(1'b0, 1'b0, 32'h000, 32'd0);         finish_req();
        issue(1'b0, 1'b0, 32'h100, 32'd0);         finish_req();
        issue(1'b0, 1'b0, 32'h000, 32'd0);         finish_req();
        issue(1'b1, 1'b0, 32'h100, 32'hCAFE_F00D); finish_req();
        issue(1'b0, 1'b0, 32'h200, 32'd0);         finish_req();
        issue(1'b0, 1'b0, 32'h000, 32'd0);         finish_req();

        // Memory held busy: request address must stay put.
        hold_busy = 1'b1; allowed = 0;
        issue(1'b0, 1'b0, 32'h0000_1FC4, 32'd0);
        @(negedge CLK);
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (exp_q.size() > 0) check("stall_daddr", daddr, exp_q[0].addr);
            check("stall_req", 32'(dREN || dWEN), 32'd1);
        end
        hold_busy = 1'b0;
        finish_req();

        for (int i = 0; i < 300; i++) begin
            st   = 1'($urandom_range(0, 1));
            both = st && ($urandom_range(0, 3) == 0);
            a    = {26'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'b00};
            issue(st, both, a, $urandom);
            finish_req();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        model_flush();
        halt = 1'b1;
        got  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if (flushed) begin
                got = 1'b1;
                break;
            end
        end
        check("flush_done", 32'(got), 32'd1);
        repeat (5) begin
            @(negedge CLK);
            check("flushed_sticky", 32'(flushed), 32'd1);
            check("done_idle_bus", 32'(dREN || dWEN), 32'd0);
        end
        check("txn_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
